// File: rtl/gen_fifo_wr_arb.sv
// ============================================================================
// Module   : gen_fifo_wr_arb
// Purpose  : N-requester round-robin burst write arbiter for one FIFO write
//            port. Optional macro GEN_FIFO_WR_ARB_PRIO_EN gives requester 0
//            strict priority at arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gen_fifo_wr_arb #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = $clog2(N),
  parameter int BURST_W   = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [N-1:0]     req_valid,
  input  logic [N-1:0]     req_last,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             fifo_wr_en,
  output logic [W-1:0]     fifo_wr_data,
  input  logic             fifo_wr_full,
  output logic             grant_vld,
  output logic [IDX_W-1:0] grant_idx
);

  localparam logic [BURST_W-1:0] C_LAST_BEAT = BURST_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]   C_IDX_MAX   = IDX_W'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic               release_grant;
  logic               beat;
  logic [IDX_W-1:0]   next_ptr;
  int                 cand;

  // First valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(rr_ptr_q) + k) % N;
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
`ifdef GEN_FIFO_WR_ARB_PRIO_EN
    if (req_valid[0]) begin
      sel_idx = '0;
    end
`endif
  end

  assign next_ptr = (grant_idx_q == C_IDX_MAX) ? '0 : grant_idx_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    beat_cnt_d    = beat_cnt_q;
    req_ready     = '0;
    fifo_wr_en    = 1'b0;
    fifo_wr_data  = '0;
    release_grant = 1'b0;
    beat          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d     = S_BURST;
          grant_idx_d = sel_idx;
          beat_cnt_d  = '0;
        end
      end
      S_BURST: begin
        fifo_wr_data = req_data[int'(grant_idx_q)*W +: W];
        if (!fifo_wr_full && !clear && !rst) begin
          req_ready[grant_idx_q] = 1'b1;
          beat                   = req_valid[grant_idx_q];
        end
        fifo_wr_en = beat;
        // A dropped valid releases the grant even without a beat.
        if (!req_valid[grant_idx_q]) begin
          release_grant = 1'b1;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (req_last[grant_idx_q] || (beat_cnt_q == C_LAST_BEAT)) begin
            release_grant = 1'b1;
          end
        end
        if (release_grant) begin
          state_d = S_IDLE;
`ifdef GEN_FIFO_WR_ARB_PRIO_EN
          if (grant_idx_q != '0) begin
            rr_ptr_d = next_ptr;
          end
`else
          rr_ptr_d = next_ptr;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      fifo_wr_data = '0;
    end

    if (clear) begin
      state_d     = S_IDLE;
      rr_ptr_d    = '0;
      grant_idx_d = '0;
      beat_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign grant_vld = (state_q == S_BURST);
  assign grant_idx = grant_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_gen_fifo_wr_arb.sv
// ============================================================================
// Module   : tb_gen_fifo_wr_arb
// Purpose  : Self-checking bench for gen_fifo_wr_arb against an abstract
//            grant/beat reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gen_fifo_wr_arb;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_last;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             fifo_wr_en;
  logic [W-1:0]     fifo_wr_data;
  logic             fifo_wr_full;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;

  always #5 clk = ~clk;

  gen_fifo_wr_arb #(.N(N), .W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_full(fifo_wr_full), .grant_vld(grant_vld), .grant_idx(grant_idx)
  );

  int checks   = 0;
  int failures = 0;

  // Model: who holds the grant, how many beats it has moved, where the scan starts.
  bit m_busy;
  int m_g, m_rr, m_beats;

  int          log_idx[$];
  logic [W-1:0] log_data[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_rr = 0; m_beats = 0;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic f, input logic c, input logic [N*W-1:0] d);
    req_valid = v; req_last = l; fifo_wr_full = f; clear = c; req_data = d;
  endtask

  // Compare one cycle of outputs against the model, then advance past the edge.
  task automatic cycle();
    logic [N-1:0] e_ready;
    logic         e_wr;
    logic [W-1:0] e_data;
    bit           rel;
    int           pick;
    #1;
    e_ready = '0; e_wr = 1'b0; e_data = '0;
    if (!rst && m_busy) begin
      e_data = req_data[m_g*W +: W];
      if (!fifo_wr_full && !clear) begin
        e_ready[m_g] = 1'b1;
        e_wr         = req_valid[m_g];
      end
    end
    check("grant_vld", 32'(grant_vld), 32'(m_busy));
    check("grant_idx", 32'(grant_idx), 32'(m_g));
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
    check("fifo_wr_data", 32'(fifo_wr_data), 32'(e_data));
    if (fifo_wr_en) begin
      log_idx.push_back(int'(grant_idx));
      log_data.push_back(fifo_wr_data);
    end
    if (rst || clear) begin
      model_reset();
    end else if (m_busy) begin
      rel = 0;
      if (!req_valid[m_g]) rel = 1;
      else if (e_wr) begin
        m_beats++;
        if (req_last[m_g] || m_beats == MB) rel = 1;
      end
      if (rel) begin
        m_busy = 0;
`ifdef GEN_FIFO_WR_ARB_PRIO_EN
        if (m_g != 0) m_rr = (m_g + 1) % N;
`else
        m_rr = (m_g + 1) % N;
`endif
      end
    end else if (|req_valid) begin
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && req_valid[(m_rr + k) % N]) pick = (m_rr + k) % N;
`ifdef GEN_FIFO_WR_ARB_PRIO_EN
      if (req_valid[0]) pick = 0;
`endif
      m_busy = 1; m_g = pick; m_beats = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    drive(4'hF, 4'h0, 1'b0, 1'b0, 32'h33221100);
    @(posedge clk);
    #1;

    // Reset with everyone requesting, then first grant goes to requester 0.
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    check("t1_first_vld", 32'(grant_vld), 32'd1);
    check("t1_first_idx", 32'(grant_idx), 32'd0);

    // Single requester 2, three-beat packet.
    drive(4'h0, 4'h0, 1'b0, 1'b1, '0); cycle();
    log_idx.delete(); log_data.delete();
    drive(4'h4, 4'h0, 1'b0, 1'b0, 32'h00A00000); cycle();
    cycle();
    drive(4'h4, 4'h0, 1'b0, 1'b0, 32'h00A10000); cycle();
    drive(4'h4, 4'h4, 1'b0, 1'b0, 32'h00A20000); cycle();
    check("t2_beats", 32'(log_idx.size()), 32'd3);
    for (int i = 0; i < log_idx.size() && i < 3; i++) begin
      check("t2_idx", 32'(log_idx[i]), 32'd2);
      check("t2_data", 32'(log_data[i]), 32'hA0 + 32'(i));
    end
    drive(4'hF, 4'h0, 1'b0, 1'b0, 32'h30201000); cycle();
    check("t2_next_grant", 32'(grant_idx), 32'd3);

    // All requesters continuously valid: 0,1,2,3,0 with four beats each.
    drive(4'h0, 4'h0, 1'b0, 1'b1, '0); cycle();
    log_idx.delete(); log_data.delete();
    drive(4'hF, 4'h0, 1'b0, 1'b0, 32'h30201000);
    for (int i = 0; i < 25; i++) cycle();
    check("t3_beats", 32'(log_idx.size()), 32'd20);
    for (int i = 0; i < log_idx.size() && i < 20; i++)
      check("t3_seq", 32'(log_idx[i]), 32'((i / 4) % N));

    // Full stalls beat 2 of requester 1 for three cycles.
    drive(4'h0, 4'h0, 1'b0, 1'b1, '0); cycle();
    log_idx.delete(); log_data.delete();
    drive(4'h2, 4'h0, 1'b0, 1'b0, 32'h00001000); cycle();
    cycle();
    drive(4'h2, 4'h0, 1'b1, 1'b0, 32'h00001100);
    for (int i = 0; i < 3; i++) begin
      cycle();
    end
    drive(4'h2, 4'h0, 1'b0, 1'b0, 32'h00001100); cycle();
    drive(4'h2, 4'h0, 1'b0, 1'b0, 32'h00001200); cycle();
    drive(4'h2, 4'h0, 1'b0, 1'b0, 32'h00001300); cycle();
    check("t4_beats", 32'(log_idx.size()), 32'd4);
    for (int i = 0; i < log_idx.size() && i < 4; i++)
      check("t4_data", 32'(log_data[i]), 32'h10 + 32'(i));
    check("t4_released", 32'(grant_vld), 32'd0);

    // Requester 3 drops valid after one beat while requester 0 waits.
    drive(4'h0, 4'h0, 1'b0, 1'b1, '0); cycle();
    drive(4'h4, 4'h4, 1'b0, 1'b0, 32'h00550000); cycle(); cycle();
    drive(4'h9, 4'h0, 1'b0, 1'b0, 32'h77000066); cycle();
`ifdef GEN_FIFO_WR_ARB_PRIO_EN
    check("t5_grant", 32'(grant_idx), 32'd0);
`else
    check("t5_grant", 32'(grant_idx), 32'd3);
    cycle();
    drive(4'h1, 4'h0, 1'b0, 1'b0, 32'h77000066); cycle();
    check("t5_dropped", 32'(grant_vld), 32'd0);
    cycle();
    check("t5_regrant", 32'(grant_idx), 32'd0);
`endif

    // Clear during beat 2 of requester 1.
    drive(4'h0, 4'h0, 1'b0, 1'b1, '0); cycle();
    drive(4'h2, 4'h0, 1'b0, 1'b0, 32'h00001000); cycle(); cycle();
    drive(4'h2, 4'h0, 1'b0, 1'b1, 32'h00001100);
    #1;
    check("t6_clear_wr", 32'(fifo_wr_en), 32'd0);
    #1;
    cycle();
    check("t6_after_vld", 32'(grant_vld), 32'd0);
    drive(4'hF, 4'h0, 1'b0, 1'b0, 32'h30201000); cycle();
    check("t6_rr_zero", 32'(grant_idx), 32'd0);

`ifdef GEN_FIFO_WR_ARB_PRIO_EN
    drive(4'h0, 4'h0, 1'b0, 1'b1, '0); cycle();
    drive(4'h2, 4'h2, 1'b0, 1'b0, 32'h00001000); cycle(); cycle();
    drive(4'h5, 4'h0, 1'b0, 1'b0, 32'h00200000); cycle(); cycle();
    check("t6_prio", 32'(grant_idx), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      drive(4'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 30) == 0),
            32'($urandom));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
